pixel_cfg_ctrl: RTL and testbench



---
 rtl/pixel_cfg_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pixel_cfg_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_cfg_ctrl.sv
// Pixel configuration write sequencer: drives one-hot select, data and a timed write
// strobe into the pixel array, fed by a small request FIFO or a full-array broadcast.
module pixel_cfg_ctrl #(
    parameter int NPIX       = 180,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            sys_clock,
    input  logic            sys_resetn,
    input  logic [7:0]      spi_cfg_addr,
    input  logic [14:0]     spi_cfg_data,
    input  logic            spi_cfg_valid,
    output logic            spi_cfg_ready,
    input  logic            bcast_req,
    input  logic [14:0]     bcast_data,
    input  logic            err_clr,
    output logic [NPIX-1:0] pixel_sel,
    output logic [14:0]     pixel_wdata,
    output logic            pixel_wren,
    output logic            busy,
    output logic            bcast_done,
    output logic            cfg_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0]   FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [8:0]      NPIX_LIM  = 9'(NPIX);
    localparam logic [7:0]      LAST_IDX  = 8'(NPIX - 1);
    localparam logic [2:0]      SETUP_LD  = 3'(SETUP_CYC - 1);
    localparam logic [2:0]      PULSE_LD  = 3'(PULSE_CYC - 1);
    localparam logic [2:0]      HOLD_LD   = 3'(HOLD_CYC - 1);
    localparam logic [NPIX-1:0] SEL_ONE   = {{(NPIX-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [NPIX-1:0] sel_q, sel_d;
    logic [14:0]     wdata_q, wdata_d;
    logic            wren_q, wren_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            ready_q, ready_d;

    logic [7:0]      mem_addr_q [FIFO_DEPTH];
    logic [7:0]      mem_addr_d [FIFO_DEPTH];
    logic [14:0]     mem_data_q [FIFO_DEPTH];
    logic [14:0]     mem_data_d [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            pend_q, pend_d;
    logic            bact_q, bact_d;
    logic [7:0]      bidx_q, bidx_d;
    logic [14:0]     bdata_q, bdata_d;

    logic            push;
    logic            pop;
    logic            new_err;
    logic [7:0]      head_addr;
    logic [14:0]     head_data;
    logic [7:0]      next_idx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        wren_d     = wren_q;
        done_d     = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        pend_d     = pend_q;
        bact_d     = bact_q;
        bidx_d     = bidx_q;
        bdata_d    = bdata_q;
        pop        = 1'b0;
        new_err    = 1'b0;
        push       = spi_cfg_valid && ready_q;
        head_addr  = mem_addr_q[rptr_q];
        head_data  = mem_data_q[rptr_q];
        next_idx   = bidx_q + 8'd1;

        if (push) begin
            mem_addr_d[wptr_q] = spi_cfg_addr;
            mem_data_d[wptr_q] = spi_cfg_data;
            wptr_d             = wptr_q + AW'(1);
        end

        // A broadcast request is only captured when none is waiting or in flight.
        if (bcast_req && !pend_q && !bact_q) begin
            pend_d  = 1'b1;
            bdata_d = bcast_data;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    bact_d  = 1'b1;
                    bidx_d  = 8'd0;
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    sel_d   = SEL_ONE;
                    wdata_d = bdata_q;
                end else if (count_q != '0) begin
                    pop = 1'b1;
                    if ({1'b0, head_addr} >= NPIX_LIM) begin
                        new_err = 1'b1;
                    end else begin
                        bact_d  = 1'b0;
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                        sel_d   = SEL_ONE << head_addr;
                        wdata_d = head_data;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_STROBE;
                    cnt_d   = PULSE_LD;
                    wren_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                    wren_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (bact_q && (bidx_q != LAST_IDX)) begin
                    // Broadcast steps straight to the next pixel without an idle gap.
                    bidx_d  = next_idx;
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    sel_d   = SEL_ONE << next_idx;
                end else begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                    if (bact_q) begin
                        bact_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
                wren_d  = 1'b0;
            end
        endcase

        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);
        ready_d = (count_d != FIFO_FULL);
        err_d   = (err_q && !err_clr) || new_err;
        busy_d  = (state_d != S_IDLE) || (count_d != '0) || pend_d;
    end

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            sel_q      <= '0;
            wdata_q    <= 15'd0;
            wren_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            bact_q     <= 1'b0;
            bidx_q     <= 8'd0;
            bdata_q    <= 15'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_addr_q[i] <= 8'd0;
                mem_data_q[i] <= 15'd0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            bact_q     <= bact_d;
            bidx_q     <= bidx_d;
            bdata_q    <= bdata_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign spi_cfg_ready = ready_q;
    assign pixel_sel     = sel_q;
    assign pixel_wdata   = wdata_q;
    assign pixel_wren    = wren_q;
    assign busy          = busy_q;
    assign bcast_done    = done_q;
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_pixel_cfg_ctrl.sv
// Self-checking bench for pixel_cfg_ctrl: a negedge monitor compares every observed
// pixel write window against a queue of expected writes filled by the stimulus tasks.
module tb_pixel_cfg_ctrl;

    localparam int NPIX  = 180;
    localparam int SETUP = 1;
    localparam int PULSE = 2;
    localparam int HOLD  = 1;
    localparam int WIN   = SETUP + PULSE + HOLD;
    localparam logic [NPIX-1:0] SEL_ONE = {{(NPIX-1){1'b0}}, 1'b1};

    logic            sys_clock;
    logic            sys_resetn;
    logic [7:0]      spi_cfg_addr;
    logic [14:0]     spi_cfg_data;
    logic            spi_cfg_valid;
    logic            spi_cfg_ready;
    logic            bcast_req;
    logic [14:0]     bcast_data;
    logic            err_clr;
    logic [NPIX-1:0] pixel_sel;
    logic [14:0]     pixel_wdata;
    logic            pixel_wren;
    logic            busy;
    logic            bcast_done;
    logic            cfg_err;

    typedef struct packed {
        logic [7:0]  addr;
        logic [14:0] data;
    } exp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [14:0] data;
        logic        expErr;
    } vec_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   readyLowSeen = 0;

    pixel_cfg_ctrl dut (
        .sys_clock    (sys_clock),
        .sys_resetn   (sys_resetn),
        .spi_cfg_addr (spi_cfg_addr),
        .spi_cfg_data (spi_cfg_data),
        .spi_cfg_valid(spi_cfg_valid),
        .spi_cfg_ready(spi_cfg_ready),
        .bcast_req    (bcast_req),
        .bcast_data   (bcast_data),
        .err_clr      (err_clr),
        .pixel_sel    (pixel_sel),
        .pixel_wdata  (pixel_wdata),
        .pixel_wren   (pixel_wren),
        .busy         (busy),
        .bcast_done   (bcast_done),
        .cfg_err      (cfg_err)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;
    always @(posedge sys_clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request at a negedge, wait for ready, let one edge accept it.
    task automatic applyStimulus(input logic [7:0] a, input logic [14:0] d, input bit doPush);
        int n = 0;
        spi_cfg_addr  = a;
        spi_cfg_data  = d;
        spi_cfg_valid = 1'b1;
        while (!spi_cfg_ready && n < 100) begin
            readyLowSeen = 1;
            @(negedge sys_clock);
            n++;
        end
        checkOutput("accept_wait", spi_cfg_ready, 1);
        if (doPush && a < NPIX) expq.push_back(exp_t'{addr: a, data: d});
        @(posedge sys_clock);
        @(negedge sys_clock);
    endtask

    task automatic pushBcast(input logic [14:0] d);
        for (int i = 0; i < NPIX; i++) expq.push_back(exp_t'{addr: 8'(i), data: d});
    endtask

    task automatic pulseBcast(input logic [14:0] d);
        bcast_req  = 1'b1;
        bcast_data = d;
        @(negedge sys_clock);
        bcast_req  = 1'b0;
    endtask

    task automatic waitIdle(input int maxCyc);
        int n = 0;
        while (busy && n < maxCyc) begin
            @(negedge sys_clock);
            n++;
        end
        checkOutput("wait_idle", busy, 0);
    endtask

    // Monitor: each new select pattern starts a write window checked against the queue.
    initial begin
        int        phase = 0;
        logic [NPIX-1:0] prevSel = '0;
        exp_t      e;
        forever begin
            @(negedge sys_clock);
            if (!sys_resetn) begin
                phase   = 0;
                prevSel = '0;
            end else begin
                if (pixel_sel != '0) begin
                    if (pixel_sel != prevSel) begin
                        if (prevSel != '0) checkOutput("win_len", phase, WIN);
                        if (expq.size() == 0) begin
                            checkOutput("unexp_write", pixel_sel, 0);
                        end else begin
                            e = expq.pop_front();
                            checkOutput("wr_sel", pixel_sel, SEL_ONE << e.addr);
                            checkOutput("wr_data", pixel_wdata, e.data);
                        end
                        phase = 0;
                    end
                    checkOutput("wr_wren", pixel_wren, (phase >= SETUP && phase < SETUP + PULSE));
                    phase++;
                end else begin
                    if (prevSel != '0) checkOutput("win_len", phase, WIN);
                    checkOutput("idle_wren", pixel_wren, 0);
                end
                prevSel = pixel_sel;
            end
        end
    end

    initial begin
        vec_t vecs[8];
        int   n;
        int   t0;
        int   t1;

        vecs[0] = '{addr: 8'd0,   data: 15'h0001, expErr: 1'b0};
        vecs[1] = '{addr: 8'd179, data: 15'h7FFE, expErr: 1'b0};
        vecs[2] = '{addr: 8'd5,   data: 15'h1234, expErr: 1'b0};
        vecs[3] = '{addr: 8'd180, data: 15'h0055, expErr: 1'b1};
        vecs[4] = '{addr: 8'd200, data: 15'h3333, expErr: 1'b1};
        vecs[5] = '{addr: 8'd255, data: 15'h4444, expErr: 1'b1};
        vecs[6] = '{addr: 8'd90,  data: 15'h2AAA, expErr: 1'b0};
        vecs[7] = '{addr: 8'd1,   data: 15'h5555, expErr: 1'b0};

        sys_resetn    = 1'b1;
        spi_cfg_addr  = 8'd0;
        spi_cfg_data  = 15'd0;
        spi_cfg_valid = 1'b0;
        bcast_req     = 1'b0;
        bcast_data    = 15'd0;
        err_clr       = 1'b0;
        #2 sys_resetn = 1'b0;
        repeat (3) @(negedge sys_clock);

        checkOutput("rst_sel", pixel_sel, 0);
        checkOutput("rst_wdata", pixel_wdata, 0);
        checkOutput("rst_wren", pixel_wren, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", bcast_done, 0);
        checkOutput("rst_err", cfg_err, 0);
        checkOutput("rst_ready", spi_cfg_ready, 1);

        // Single write straight out of reset: exact latency and strobe placement.
        sys_resetn = 1'b1;
        applyStimulus(8'd5, 15'h1234, 1);
        spi_cfg_valid = 1'b0;
        checkOutput("lat_sel_early", pixel_sel, 0);
        for (int c = 1; c <= WIN; c++) begin
            @(negedge sys_clock);
            checkOutput("lat_sel", pixel_sel, SEL_ONE << 5);
            checkOutput("lat_wdata", pixel_wdata, 15'h1234);
            checkOutput("lat_wren", pixel_wren, (c == 2 || c == 3));
        end
        @(negedge sys_clock);
        checkOutput("lat_sel_end", pixel_sel, 0);
        checkOutput("lat_wdata_keep", pixel_wdata, 15'h1234);
        waitIdle(20);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].data, !vecs[i].expErr);
            spi_cfg_valid = 1'b0;
            waitIdle(20);
            checkOutput("vec_err", cfg_err, vecs[i].expErr);
            if (vecs[i].expErr) begin
                err_clr = 1'b1;
                @(negedge sys_clock);
                err_clr = 1'b0;
                @(negedge sys_clock);
                checkOutput("vec_err_clr", cfg_err, 0);
            end
        end

        // err_clr landing on the same edge as a new error leaves the flag set.
        applyStimulus(8'd200, 15'h0001, 0);
        spi_cfg_valid = 1'b0;
        err_clr = 1'b1;
        @(negedge sys_clock);
        err_clr = 1'b0;
        checkOutput("err_clr_same", cfg_err, 1);
        err_clr = 1'b1;
        @(negedge sys_clock);
        err_clr = 1'b0;
        @(negedge sys_clock);
        checkOutput("err_clr_after", cfg_err, 0);
        waitIdle(20);

        // Back-to-back requests fill the FIFO; all must drain in order.
        readyLowSeen = 0;
        for (int i = 0; i < 5; i++) applyStimulus(8'(20 + i), 15'(16'h0100 + i), 1);
        checkOutput("fifo_full_ready", spi_cfg_ready, 0);
        applyStimulus(8'd25, 15'h0105, 1);
        spi_cfg_valid = 1'b0;
        checkOutput("ready_low_seen", readyLowSeen, 1);
        waitIdle(100);
        checkOutput("b2b_drained", expq.size(), 0);

        // Broadcast from idle with a single write queued behind it.
        pushBcast(15'h7FFF);
        pulseBcast(15'h7FFF);
        n = 0;
        while (!pixel_sel[0] && n < 20) begin
            @(negedge sys_clock);
            n++;
        end
        checkOutput("bc_start", pixel_sel[0], 1);
        t0 = cyc;
        applyStimulus(8'd3, 15'h0ABC, 1);
        spi_cfg_valid = 1'b0;
        n = 0;
        while (!bcast_done && n < 900) begin
            @(negedge sys_clock);
            n++;
        end
        checkOutput("bc_done_seen", bcast_done, 1);
        t1 = cyc;
        checkOutput("bc_len", t1 - t0, NPIX * WIN);
        @(negedge sys_clock);
        checkOutput("bc_done_pulse", bcast_done, 0);
        waitIdle(50);
        checkOutput("bc_drained", expq.size(), 0);

        // Broadcast requested mid single write overtakes an already-queued write;
        // repeated requests while pending or running are ignored.
        applyStimulus(8'd10, 15'h000A, 1);
        applyStimulus(8'd11, 15'h000B, 0);
        spi_cfg_valid = 1'b0;
        pushBcast(15'h1111);
        expq.push_back(exp_t'{addr: 8'd11, data: 15'h000B});
        pulseBcast(15'h1111);
        pulseBcast(15'h0F0F);
        n = 0;
        while (!pixel_sel[0] && n < 20) begin
            @(negedge sys_clock);
            n++;
        end
        checkOutput("bc2_start", pixel_sel[0], 1);
        pulseBcast(15'h0001);
        waitIdle(1000);
        checkOutput("bc2_drained", expq.size(), 0);

        // Reset in the strobe of the last broadcast pixel, with a write queued.
        pushBcast(15'h2AAA);
        pulseBcast(15'h2AAA);
        applyStimulus(8'd7, 15'h0777, 0);
        spi_cfg_valid = 1'b0;
        n = 0;
        while (!(pixel_sel[179] && pixel_wren) && n < 900) begin
            @(negedge sys_clock);
            n++;
        end
        checkOutput("rst_at_179", pixel_sel[179] && pixel_wren, 1);
        #1 sys_resetn = 1'b0;
        #1;
        checkOutput("mid_rst_wren", pixel_wren, 0);
        checkOutput("mid_rst_sel", pixel_sel, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ready", spi_cfg_ready, 1);
        expq.delete();
        repeat (2) @(negedge sys_clock);
        sys_resetn = 1'b1;
        repeat (10) @(negedge sys_clock);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_sel", pixel_sel, 0);

        applyStimulus(8'd179, 15'h5555, 1);
        spi_cfg_valid = 1'b0;
        waitIdle(20);
        checkOutput("final_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
